// File: rtl/sample_capture_buffer_pkg.sv
// Shared types and sizes for the ADC sample capture buffer.
package sample_capture_buffer_pkg;
  localparam int ADDR_W_DEF   = 12;
  localparam int DATA_W_DEF   = 16;
  localparam int SAMPLE_DEPTH = 1 << ADDR_W_DEF;

  typedef enum logic [1:0] {IDLE, WAIT_TRIG, FILL, DONE} state_e;
endpackage

// File: rtl/sample_capture_buffer_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered output.
module sample_ram #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Only the output register is reset; the array keeps its contents.
  always_ff @(posedge clk) begin
    if (reset) o_rdata <= '0;
    else       o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/sample_capture_buffer.sv
// Arm/trigger capture of one buffer-depth burst, frozen for CPU readback.
module sample_capture_buffer
  import sample_capture_buffer_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm,
  input  logic              trigger,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  input  logic [ADDR_W-1:0] read_address,
  output logic [DATA_W-1:0] readdata,
  output logic              read_valid,
  output logic              capture_done,
  output logic              busy,
  output logic [ADDR_W:0]   wr_count
);
  localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W+1)'(2**ADDR_W);

  state_e            r_state, w_next;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_ra_q, r_ra_qq;
  logic              w_we, w_last;

  // arm takes priority over everything, including a write in the same cycle.
  assign w_we   = sample_valid && !arm &&
                  ((r_state == WAIT_TRIG && trigger) || r_state == FILL);
  assign w_last = (r_wr_ptr == {ADDR_W{1'b1}});

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (arm) w_next = WAIT_TRIG;
    else begin
      case (r_state)
        WAIT_TRIG: if (trigger) w_next = FILL;
        FILL:      if (w_we && w_last) w_next = DONE;
        default:   w_next = r_state;
      endcase
    end
  end

  always_comb begin
    busy         = (r_state == WAIT_TRIG) || (r_state == FILL);
    capture_done = (r_state == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset || arm) begin
      r_wr_ptr <= '0;
      wr_count <= '0;
    end else if (w_we) begin
      r_wr_ptr <= r_wr_ptr + 1'b1;
      if (wr_count != CNT_MAX) wr_count <= wr_count + 1'b1;
    end
  end

  // r_ra_qq tracks the address whose word is currently on readdata.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ra_q  <= '0;
      r_ra_qq <= '0;
    end else begin
      r_ra_q  <= read_address;
      r_ra_qq <= r_ra_q;
    end
  end

  assign read_valid = capture_done && (read_address == r_ra_q) && (r_ra_q == r_ra_qq);

  sample_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (sample_data),
    .i_raddr (r_ra_q),
    .o_rdata (readdata)
  );
endmodule

// File: tb/tb_sample_capture_buffer.sv
// Directed bench for sample_capture_buffer with immediate-assertion checks.
module tb_sample_capture_buffer;
  import sample_capture_buffer_pkg::*;

  logic        clk = 1'b0;
  logic        reset, arm, trigger, sample_valid;
  logic [15:0] sample_data;
  logic [11:0] read_address;
  logic [15:0] readdata;
  logic        read_valid, capture_done, busy;
  logic [12:0] wr_count;

  int n_checks = 0;
  int n_err    = 0;

  sample_capture_buffer dut (
    .clk          (clk),
    .reset        (reset),
    .arm          (arm),
    .trigger      (trigger),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .read_address (read_address),
    .readdata     (readdata),
    .read_valid   (read_valid),
    .capture_done (capture_done),
    .busy         (busy),
    .wr_count     (wr_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full capture from WAIT_TRIG: sample i carries i ^ m, address polled throughout.
  task automatic run_capture(input logic [15:0] m);
    int done_at  = -1;
    int poll_bad = 0;
    sample_valid = 1'b1;
    for (int i = 0; i < 5000 && done_at < 0; i++) begin
      trigger      = (i == 0);
      sample_data  = 16'(i) ^ m;
      read_address = 12'(i) ^ 12'h5A5;
      #1;
      if (capture_done) done_at = i;
      else begin
        if (read_valid) poll_bad++;
        if (i == 100) chk("wr_count_at_100", 32'(wr_count), 32'd100);
        step();
      end
    end
    sample_valid = 1'b0;
    trigger      = 1'b0;
    // Counts trigger cycle through first capture_done cycle, inclusive.
    chk("done_latency", done_at + 1, 32'd4097);
    chk("wr_count_full", 32'(wr_count), 32'd4096);
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("rv_during_fill", poll_bad, 32'd0);
    step();
    chk("rv_held_1", 32'(read_valid), 32'd0);
    step();
    chk("rv_held_2", 32'(read_valid), 32'd1);
    chk("rd_held_2", 32'(readdata), 32'(16'h05A5 ^ m));
  endtask

  task automatic read_hold(input logic [11:0] a, input logic [15:0] exp);
    read_address = a;
    #1;
    chk("rv_change", 32'(read_valid), 32'd0);
    step();
    chk("rv_hold1", 32'(read_valid), 32'd0);
    step();
    chk("rv_hold2", 32'(read_valid), 32'd1);
    chk("rd_hold2", 32'(readdata), 32'(exp));
  endtask

  task automatic chk_reset_vals();
    chk("rst_readdata", 32'(readdata), 32'd0);
    chk("rst_read_valid", 32'(read_valid), 32'd0);
    chk("rst_capture_done", 32'(capture_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr_count", 32'(wr_count), 32'd0);
  endtask

  initial begin
    reset = 1'b1; arm = 1'b0; trigger = 1'b0; sample_valid = 1'b0;
    sample_data = '0; read_address = '0;
    step(); step();
    reset = 1'b0;
    chk_reset_vals();

    // First full capture with data = index
    arm = 1'b1; step(); arm = 1'b0;
    chk("busy_after_arm", 32'(busy), 32'd1);
    chk("wr_count_after_arm", 32'(wr_count), 32'd0);
    run_capture(16'h0000);
    read_hold(12'h000, 16'h0000);
    read_hold(12'h7FF, 16'h07FF);
    read_hold(12'hFFF, 16'h0FFF);

    // Arm from IDLE, samples without trigger are dropped
    reset = 1'b1; step(); reset = 1'b0;
    arm = 1'b1; step(); arm = 1'b0;
    sample_valid = 1'b1; sample_data = 16'h5555;
    step(); step(); step();
    sample_valid = 1'b0;
    chk("no_trig_wr_count", 32'(wr_count), 32'd0);
    chk("no_trig_busy", 32'(busy), 32'd1);
    trigger = 1'b1; sample_valid = 1'b1; sample_data = 16'hABCD;
    step();
    trigger = 1'b0; sample_valid = 1'b0;
    chk("trig_sample_count", 32'(wr_count), 32'd1);
    read_address = 12'h000;
    step(); step();
    chk("idx0_abcd", 32'(readdata), 32'h0000ABCD);
    chk("rv_not_done", 32'(read_valid), 32'd0);

    // arm and trigger together: arm wins, trigger ignored
    arm = 1'b1; trigger = 1'b1; sample_valid = 1'b1; sample_data = 16'h1111;
    step();
    arm = 1'b0; trigger = 1'b0; sample_data = 16'h3333;
    chk("arm_trig_count", 32'(wr_count), 32'd0);
    chk("arm_trig_busy", 32'(busy), 32'd1);
    step();
    chk("wait_trig_no_write", 32'(wr_count), 32'd0);
    trigger = 1'b1; sample_data = 16'h2222;
    step();
    trigger = 1'b0; sample_valid = 1'b0;
    chk("next_trig_fill", 32'(wr_count), 32'd1);
    step(); step();
    chk("idx0_2222", 32'(readdata), 32'h00002222);

    // Reset 100 samples into FILL, then a clean full capture
    arm = 1'b1; step(); arm = 1'b0;
    sample_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      trigger = (i == 0);
      sample_data = 16'(i) ^ 16'h8000;
      step();
    end
    trigger = 1'b0;
    chk("mid_fill_count", 32'(wr_count), 32'd100);
    reset = 1'b1; sample_valid = 1'b0;
    step();
    reset = 1'b0;
    chk_reset_vals();
    arm = 1'b1; step(); arm = 1'b0;
    run_capture(16'hFFFF);
    read_hold(12'h064, 16'hFF9B);
    read_hold(12'hFFF, 16'hF000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
